// File: rtl/nss_pkg.sv
// nss_pkg: shared state encoding and constants for the nibble-serial subtractor.
package nss_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} nss_state_t;
    localparam int NIB_W = 4;
    localparam logic RST_DIFF = '0;
endpackage

// File: rtl/nss_nibble_add.sv
// nss_nibble_add: 4-bit carry-lookahead adder, one nibble step of the serial subtractor.
module nss_nibble_add (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [3:0] w_g, w_p, w_c;
    assign w_g = a & b;
    assign w_p = a ^ b;
    assign w_c[0] = ci;
    assign w_c[1] = w_g[0] | (w_p[0] & ci);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & ci);
    assign co = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0]) | (&w_p & ci);
    assign s = w_p ^ w_c;
endmodule

// File: rtl/nibble_serial_sub.sv
// nibble_serial_sub: diff = a - b, one nibble per clock, LSB first, valid/ready on both sides.
// Define NSS_SAT_EN to saturate diff on signed overflow instead of wrapping.
module nibble_serial_sub
    import nss_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);
    localparam int NIB = WIDTH / NIB_W;
    localparam int CW = $clog2(NIB);
    localparam logic [CW-1:0] CNT_LAST = CW'(NIB - 1);

    nss_state_t            r_state;
    logic [CW-1:0]         r_cnt;
    logic [WIDTH-1:0]      r_a, r_nb, r_diff;
    logic [WIDTH-NIB_W-1:0] r_acc;
    logic                  r_c, r_a_msb, r_nb_msb, r_borrow, r_ovf;
    logic [NIB_W-1:0]      w_s;
    logic                  w_co, w_ovf;
    logic [WIDTH-1:0]      w_raw, w_res;

    nss_nibble_add u_add (
        .a (r_a[NIB_W-1:0]),
        .b (r_nb[NIB_W-1:0]),
        .ci(r_c),
        .s (w_s),
        .co(w_co)
    );

    // Sign bits are kept aside because the operand registers are shifted away by the last step.
    assign w_raw = {w_s, r_acc};
    assign w_ovf = (r_a_msb == r_nb_msb) & (w_s[NIB_W-1] != r_a_msb);
`ifdef NSS_SAT_EN
    assign w_res = w_ovf ? {r_a_msb, {(WIDTH-1){~r_a_msb}}} : w_raw;
`else
    assign w_res = w_raw;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_nb     <= '0;
            r_acc    <= '0;
            r_c      <= 1'b0;
            r_a_msb  <= 1'b0;
            r_nb_msb <= 1'b0;
            r_diff   <= {WIDTH{RST_DIFF}};
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_a      <= a;
                    r_nb     <= ~b;
                    r_a_msb  <= a[WIDTH-1];
                    r_nb_msb <= ~b[WIDTH-1];
                    r_c      <= 1'b1;
                    r_cnt    <= '0;
                    r_state  <= RUN;
                end
                RUN: begin
                    r_a   <= r_a >> NIB_W;
                    r_nb  <= r_nb >> NIB_W;
                    r_acc <= w_raw[WIDTH-1:NIB_W];
                    r_c   <= w_co;
                    r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_diff   <= w_res;
                        r_borrow <= ~w_co;
                        r_ovf    <= w_ovf;
                        r_state  <= DONE;
                    end
                end
                DONE: if (out_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign diff      = r_diff;
    assign borrow    = r_borrow;
    assign overflow  = r_ovf;
endmodule
